// File: rtl/sync_fifo_prog_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package sync_fifo_prog_pkg;

    // Read-port behaviour selected at elaboration time
    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, one cycle of latency
        FIFO_FWFT = 1'b1    // head word presented combinationally
    } fifo_mode_e;

    // Sticky error flags, kept together so they update in one place
    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

    // Advance a circular pointer, wrapping from depth-1 back to zero
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer-facing bundle of the programmable FIFO.
// master = the block driving requests and thresholds, slave = the FIFO itself.
interface sync_fifo_prog_if
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    // Requests and configuration
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [AW:0]       i_alm_full_th;
    logic [AW:0]       i_alm_empty_th;
    logic              i_clr_err;

    // Data and status
    logic [DATA_W-1:0] o_rddata;
    logic              o_rd_valid;
    logic [AW:0]       o_count;
    logic              o_empty;
    logic              o_full;
    logic              o_alm_empty;
    logic              o_alm_full;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wren, i_wrdata, i_rden, i_alm_full_th, i_alm_empty_th, i_clr_err,
        input  o_rddata, o_rd_valid, o_count, o_empty, o_full,
               o_alm_empty, o_alm_full, o_overflow, o_underflow
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_alm_full_th, i_alm_empty_th, i_clr_err,
        output o_rddata, o_rd_valid, o_count, o_empty, o_full,
               o_alm_empty, o_alm_full, o_overflow, o_underflow
    );

endinterface

// File: rtl/sync_fifo_prog_mem.sv
// Storage for the FIFO: simple dual-port array, synchronous write,
// asynchronous read so the top can either register or forward the head word.
module sync_fifo_prog_mem
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    // Contents are deliberately not reset; occupancy is tracked by the pointers
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store an accepted write word
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Programmable single-clock FIFO: pointer/occupancy control, threshold flags,
// sticky error flags and a standard or first-word-fall-through read stage.
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    sync_fifo_prog_if.slave  fifo_if
);

    localparam int          AW        = $clog2(DEPTH);
    localparam fifo_mode_e  MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    // Registered state
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    fifo_err_t         r_err;

    // Combinational helpers
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [AW-1:0]     w_wr_ptr_next;
    logic [AW-1:0]     w_rd_ptr_next;
    logic [AW:0]       w_count_next;
    fifo_err_t         w_err_next;
    logic [DATA_W-1:0] w_mem_rdata;

    // Status derives from the registered count, so flags move one cycle after an op
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);

    // A read is honoured only when data exists; a write into a full FIFO is
    // honoured only if a read frees a slot in the same cycle. No empty bypass.
    assign w_rd_acc = fifo_if.i_rden & ~w_empty;
    assign w_wr_acc = fifo_if.i_wren & (~w_full | w_rd_acc);

    sync_fifo_prog_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo_if.i_wrdata),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rdata)
    );

    // Next pointer, occupancy and error values
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        w_err_next    = r_err;

        if (w_wr_acc) begin
            w_wr_ptr_next = AW'(ptr_inc(32'(r_wr_ptr), DEPTH));
        end
        if (w_rd_acc) begin
            w_rd_ptr_next = AW'(ptr_inc(32'(r_rd_ptr), DEPTH));
        end

        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_next = r_count - 1'b1;
        end

        // Clearing drops old errors, but an error in the same cycle still latches
        if (fifo_if.i_clr_err) begin
            w_err_next = '0;
        end
        if (fifo_if.i_wren && !w_wr_acc) begin
            w_err_next.ovf = 1'b1;
        end
        if (fifo_if.i_rden && !w_rd_acc) begin
            w_err_next.udf = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_err    <= w_err_next;
        end
    end

    // Status outputs; thresholds are compared unsigned with no clamping
    assign fifo_if.o_count     = r_count;
    assign fifo_if.o_empty     = w_empty;
    assign fifo_if.o_full      = w_full;
    assign fifo_if.o_alm_empty = (r_count <= fifo_if.i_alm_empty_th);
    assign fifo_if.o_alm_full  = (r_count >= fifo_if.i_alm_full_th);
    assign fifo_if.o_overflow  = r_err.ovf;
    assign fifo_if.o_underflow = r_err.udf;

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is always presented; a read pops what is shown
            assign fifo_if.o_rddata   = w_mem_rdata;
            assign fifo_if.o_rd_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_rddata;
            logic              r_rd_valid;

            // Capture the popped word; hold it until the next accepted read
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_rddata   <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rddata <= w_mem_rdata;
                    end
                end
            end

            assign fifo_if.o_rddata   = r_rddata;
            assign fifo_if.o_rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed and randomised checks of sync_fifo_prog in both read modes.
// Both instances see identical stimulus; u_std is FWFT=0, u_fwft is FWFT=1.
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wren = 1'b0;
    logic       rden = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wrdata = 8'h00;
    logic [4:0] th_full = 5'd14;
    logic [4:0] th_empty = 5'd2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_prog_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus1 ();

    assign bus0.i_wren = wren;           assign bus1.i_wren = wren;
    assign bus0.i_wrdata = wrdata;       assign bus1.i_wrdata = wrdata;
    assign bus0.i_rden = rden;           assign bus1.i_rden = rden;
    assign bus0.i_alm_full_th = th_full; assign bus1.i_alm_full_th = th_full;
    assign bus0.i_alm_empty_th = th_empty; assign bus1.i_alm_empty_th = th_empty;
    assign bus0.i_clr_err = clr_err;     assign bus1.i_clr_err = clr_err;

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk (clk), .rstn (rstn), .fifo_if (bus0)
    );
    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk (clk), .rstn (rstn), .fifo_if (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
        tick();
        rstn = 1'b1;
        $display("reset: count=%0d empty=%0b", bus0.o_count, bus0.o_empty);
        checks++; if (bus0.o_empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", bus0.o_empty); else passed++;
        checks++; if (bus0.o_alm_empty !== 1'b1) $display("FAIL reset_alm_empty got %0b exp 1", bus0.o_alm_empty); else passed++;
        checks++; if (bus0.o_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", bus0.o_count); else passed++;
        checks++; if (bus0.o_full !== 1'b0) $display("FAIL reset_full got %0b exp 0", bus0.o_full); else passed++;
        checks++; if (bus0.o_alm_full !== 1'b0) $display("FAIL reset_alm_full got %0b exp 0", bus0.o_alm_full); else passed++;
        checks++; if (bus0.o_overflow !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", bus0.o_overflow); else passed++;
        checks++; if (bus0.o_underflow !== 1'b0) $display("FAIL reset_udf got %0b exp 0", bus0.o_underflow); else passed++;
        checks++; if (bus0.o_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b exp 0", bus0.o_rd_valid); else passed++;
        checks++; if (bus0.o_rddata !== 8'h00) $display("FAIL reset_rddata got %02h exp 00", bus0.o_rddata); else passed++;
        checks++; if (bus1.o_rd_valid !== 1'b0) $display("FAIL reset_fwft_valid got %0b exp 0", bus1.o_rd_valid); else passed++;
    endtask

    task automatic test_fill();
        int n;
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; wrdata = 8'(i);
            tick();
            n = i + 1;
            $display("fill: wr %02h -> count=%0d alm_full=%0b full=%0b", wrdata, bus0.o_count, bus0.o_alm_full, bus0.o_full);
            checks++; if (bus0.o_count !== 5'(n)) $display("FAIL fill_count got %0d exp %0d", bus0.o_count, n); else passed++;
            checks++; if (bus0.o_alm_full !== (n >= 14)) $display("FAIL fill_alm_full at %0d got %0b", n, bus0.o_alm_full); else passed++;
            checks++; if (bus0.o_full !== (n == 16)) $display("FAIL fill_full at %0d got %0b", n, bus0.o_full); else passed++;
            checks++; if (bus0.o_alm_empty !== (n <= 2)) $display("FAIL fill_alm_empty at %0d got %0b", n, bus0.o_alm_empty); else passed++;
        end
        wrdata = 8'hAA;
        tick();
        wren = 1'b0;
        $display("fill: wr AA on full -> count=%0d ovf=%0b", bus0.o_count, bus0.o_overflow);
        checks++; if (bus0.o_count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", bus0.o_count); else passed++;
        checks++; if (bus0.o_overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", bus0.o_overflow); else passed++;
        checks++; if (bus0.o_underflow !== 1'b0) $display("FAIL ovf_udf got %0b exp 0", bus0.o_underflow); else passed++;
        checks++; if (bus1.o_rddata !== 8'h00) $display("FAIL ovf_fwft_head got %02h exp 00", bus1.o_rddata); else passed++;
    endtask

    task automatic test_drain_std();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus1.o_rd_valid !== 1'b1 || bus1.o_rddata !== 8'(i))
                $display("FAIL drain_fwft_head got v=%0b %02h exp v=1 %02h", bus1.o_rd_valid, bus1.o_rddata, 8'(i)); else passed++;
            rden = 1'b1;
            tick();
            $display("drain: rd -> valid=%0b data=%02h count=%0d", bus0.o_rd_valid, bus0.o_rddata, bus0.o_count);
            checks++; if (bus0.o_rd_valid !== 1'b1 || bus0.o_rddata !== 8'(i))
                $display("FAIL drain_data got v=%0b %02h exp v=1 %02h", bus0.o_rd_valid, bus0.o_rddata, 8'(i)); else passed++;
            checks++; if (bus0.o_count !== 5'(15 - i)) $display("FAIL drain_count got %0d exp %0d", bus0.o_count, 15 - i); else passed++;
        end
        tick();
        rden = 1'b0;
        $display("drain: rd on empty -> udf=%0b count=%0d", bus0.o_underflow, bus0.o_count);
        checks++; if (bus0.o_underflow !== 1'b1) $display("FAIL udf_flag got %0b exp 1", bus0.o_underflow); else passed++;
        checks++; if (bus0.o_count !== 5'd0) $display("FAIL udf_count got %0d exp 0", bus0.o_count); else passed++;
        checks++; if (bus0.o_rd_valid !== 1'b0) $display("FAIL udf_rd_valid got %0b exp 0", bus0.o_rd_valid); else passed++;
        checks++; if (bus0.o_empty !== 1'b1 || bus1.o_rd_valid !== 1'b0)
            $display("FAIL udf_empty got empty=%0b fwft_v=%0b exp 1/0", bus0.o_empty, bus1.o_rd_valid); else passed++;
        tick();
        checks++; if (bus0.o_rddata !== 8'h0F) $display("FAIL hold_rddata got %02h exp 0f", bus0.o_rddata); else passed++;
    endtask

    task automatic test_clr_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        $display("clr_err: ovf=%0b udf=%0b", bus0.o_overflow, bus0.o_underflow);
        checks++; if (bus0.o_overflow !== 1'b0 || bus0.o_underflow !== 1'b0)
            $display("FAIL clr_err got ovf=%0b udf=%0b exp 0/0", bus0.o_overflow, bus0.o_underflow); else passed++;
        clr_err = 1'b1; rden = 1'b1;
        tick();
        clr_err = 1'b0; rden = 1'b0;
        $display("clr_err+rd empty: ovf=%0b udf=%0b", bus0.o_overflow, bus0.o_underflow);
        checks++; if (bus0.o_underflow !== 1'b1 || bus0.o_overflow !== 1'b0)
            $display("FAIL clr_vs_event got ovf=%0b udf=%0b exp 0/1", bus0.o_overflow, bus0.o_underflow); else passed++;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_full_rdwr();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; wrdata = 8'h10 + 8'(i);
            tick();
        end
        wrdata = 8'h55; rden = 1'b1;
        tick();
        wren = 1'b0;
        $display("full rd+wr 55: count=%0d ovf=%0b data=%02h", bus0.o_count, bus0.o_overflow, bus0.o_rddata);
        checks++; if (bus0.o_count !== 5'd16) $display("FAIL fullrw_count got %0d exp 16", bus0.o_count); else passed++;
        checks++; if (bus0.o_overflow !== 1'b0) $display("FAIL fullrw_ovf got %0b exp 0", bus0.o_overflow); else passed++;
        checks++; if (bus0.o_rd_valid !== 1'b1 || bus0.o_rddata !== 8'h10)
            $display("FAIL fullrw_first got v=%0b %02h exp v=1 10", bus0.o_rd_valid, bus0.o_rddata); else passed++;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? (8'h11 + 8'(k)) : 8'h55;
            tick();
            $display("fullrw drain: data=%02h", bus0.o_rddata);
            checks++; if (bus0.o_rd_valid !== 1'b1 || bus0.o_rddata !== exp)
                $display("FAIL fullrw_drain got v=%0b %02h exp v=1 %02h", bus0.o_rd_valid, bus0.o_rddata, exp); else passed++;
        end
        rden = 1'b0;
        checks++; if (bus0.o_count !== 5'd0) $display("FAIL fullrw_end_count got %0d exp 0", bus0.o_count); else passed++;
        tick();
    endtask

    task automatic test_fwft_first();
        wren = 1'b1; wrdata = 8'h3C; rden = 1'b1;
        tick();
        wren = 1'b0; rden = 1'b0;
        $display("empty rd+wr 3C: count=%0d udf=%0b fwft v=%0b d=%02h", bus0.o_count, bus0.o_underflow, bus1.o_rd_valid, bus1.o_rddata);
        checks++; if (bus0.o_count !== 5'd1) $display("FAIL nobypass_count got %0d exp 1", bus0.o_count); else passed++;
        checks++; if (bus0.o_underflow !== 1'b1) $display("FAIL nobypass_udf got %0b exp 1", bus0.o_underflow); else passed++;
        checks++; if (bus0.o_rd_valid !== 1'b0) $display("FAIL nobypass_std_valid got %0b exp 0", bus0.o_rd_valid); else passed++;
        checks++; if (bus1.o_rd_valid !== 1'b1 || bus1.o_rddata !== 8'h3C)
            $display("FAIL fwft_show got v=%0b %02h exp v=1 3c", bus1.o_rd_valid, bus1.o_rddata); else passed++;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        $display("pop 3C: std v=%0b d=%02h fwft v=%0b", bus0.o_rd_valid, bus0.o_rddata, bus1.o_rd_valid);
        checks++; if (bus0.o_rd_valid !== 1'b1 || bus0.o_rddata !== 8'h3C)
            $display("FAIL fwft_pop_std got v=%0b %02h exp v=1 3c", bus0.o_rd_valid, bus0.o_rddata); else passed++;
        checks++; if (bus1.o_rd_valid !== 1'b0 || bus0.o_count !== 5'd0)
            $display("FAIL fwft_pop_empty got v=%0b count=%0d exp 0/0", bus1.o_rd_valid, bus0.o_count); else passed++;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_thresholds();
        th_full = 5'd0; th_empty = 5'd0;
        #1;
        $display("th 0/0 at count 0: alm_full=%0b alm_empty=%0b", bus0.o_alm_full, bus0.o_alm_empty);
        checks++; if (bus0.o_alm_full !== 1'b1 || bus0.o_alm_empty !== 1'b1)
            $display("FAIL th_zero got af=%0b ae=%0b exp 1/1", bus0.o_alm_full, bus0.o_alm_empty); else passed++;
        wren = 1'b1; wrdata = 8'h77;
        tick();
        wren = 1'b0; th_full = 5'd17;
        #1;
        $display("th 17/0 at count 1: alm_full=%0b alm_empty=%0b", bus0.o_alm_full, bus0.o_alm_empty);
        checks++; if (bus0.o_alm_full !== 1'b0 || bus0.o_alm_empty !== 1'b0)
            $display("FAIL th_out_of_range got af=%0b ae=%0b exp 0/0", bus0.o_alm_full, bus0.o_alm_empty); else passed++;
        th_full = 5'd1; th_empty = 5'd1;
        #1;
        checks++; if (bus0.o_alm_full !== 1'b1 || bus0.o_alm_empty !== 1'b1)
            $display("FAIL th_equal got af=%0b ae=%0b exp 1/1", bus0.o_alm_full, bus0.o_alm_empty); else passed++;
        th_full = 5'd14; th_empty = 5'd2;
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       e_ovf, e_udf, e_vld, w, r, c, ra, wa;
        logic [7:0] e_last, d;
        logic [10:0] got_st, exp_st;
        int wprob;
        // start from a known read-data register
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        e_ovf = 1'b0; e_udf = 1'b0; e_vld = 1'b0; e_last = 8'h00;
        for (int op = 0; op < 1000; op++) begin
            if (op == 500) begin
                wren = 1'b0; rden = 1'b0; clr_err = 1'b0; rstn = 1'b0;
                tick();
                rstn = 1'b1;
                q.delete(); e_ovf = 1'b0; e_udf = 1'b0; e_vld = 1'b0; e_last = 8'h00;
                $display("rnd reset: count=%0d empty=%0b", bus0.o_count, bus0.o_empty);
                checks++; if (bus0.o_count !== 5'd0 || bus0.o_empty !== 1'b1)
                    $display("FAIL rnd_reset got count=%0d empty=%0b exp 0/1", bus0.o_count, bus0.o_empty); else passed++;
            end
            wprob = ((op % 250) < 125) ? 70 : 30;
            w = ($urandom_range(0, 99) < wprob);
            r = ($urandom_range(0, 99) < (100 - wprob));
            c = ($urandom_range(0, 39) == 0);
            d = 8'($urandom);
            // FWFT head must equal the oldest queued word before this edge
            checks++;
            if (q.size() > 0) begin
                if (bus1.o_rd_valid !== 1'b1 || bus1.o_rddata !== q[0])
                    $display("FAIL rnd_fwft_head got v=%0b %02h exp v=1 %02h", bus1.o_rd_valid, bus1.o_rddata, q[0]);
                else passed++;
            end else begin
                if (bus1.o_rd_valid !== 1'b0) $display("FAIL rnd_fwft_empty got v=%0b exp 0", bus1.o_rd_valid);
                else passed++;
            end
            ra = r && (q.size() > 0);
            wa = w && ((q.size() < DEPTH) || ra);
            e_ovf = (e_ovf && !c) || (w && !wa);
            e_udf = (e_udf && !c) || (r && !ra);
            e_vld = ra;
            if (ra) e_last = q.pop_front();
            if (wa) q.push_back(d);
            wren = w; rden = r; wrdata = d; clr_err = c;
            tick();
            wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
            got_st = {bus0.o_count, bus0.o_empty, bus0.o_full, bus0.o_alm_empty, bus0.o_alm_full,
                      bus0.o_overflow, bus0.o_underflow};
            exp_st = {5'(q.size()), q.size() == 0, q.size() == DEPTH, q.size() <= 2, q.size() >= 14,
                      e_ovf, e_udf};
            $display("rnd %0d wr=%0b d=%02h rd=%0b clr=%0b -> count=%0d", op, w, d, r, c, bus0.o_count);
            checks++; if (got_st !== exp_st)
                $display("FAIL rnd_status got %03h exp %03h (count,empty,full,ae,af,ovf,udf)", got_st, exp_st); else passed++;
            checks++; if (bus0.o_rd_valid !== e_vld || bus0.o_rddata !== e_last)
                $display("FAIL rnd_std_read got v=%0b %02h exp v=%0b %02h", bus0.o_rd_valid, bus0.o_rddata, e_vld, e_last); else passed++;
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_fill();
        test_drain_std();
        test_clr_err();
        test_full_rdwr();
        test_fwft_first();
        test_thresholds();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
